// File: rtl/noc_injector.sv
// noc_injector: source-side network interface. Turns one message descriptor
// plus a stream of payload words into a wormhole packet (HEADER, BODY..., TAIL)
// and drives it into a router input port over an enable/ack flit handshake.

package noc_injector_pkg;
  localparam int COORD_W   = 4;
  localparam int ADDR_W    = 2 * COORD_W;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    FT_NONE   = 2'd0,
    FT_HEADER = 2'd1,
    FT_BODY   = 2'd2,
    FT_TAIL   = 2'd3
  } flit_type_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } addr_t;

  typedef struct packed {
    logic [PAYLOAD_W-ADDR_W-1:0] rsvd;
    addr_t                       dst_addr;
  } header_t;

  typedef struct packed {
    flit_type_e           flit_type;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);
endpackage

module noc_injector
  import noc_injector_pkg::*;
#(
  parameter int X     = 1,
  parameter int Y     = 1,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [ADDR_W-1:0]    msg_dst,
  input  logic [LEN_W-1:0]     msg_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [PAYLOAD_W-1:0] data,
  output logic [FLIT_W-1:0]    flit_o,
  output logic                 enable_o,
  input  logic                 ack_i,
  output logic                 busy,
  output logic                 pkt_sent,
  output logic                 err_self
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_SEND, S_LAST} state_e;

  localparam logic [ADDR_W-1:0] SELF_ADDR = {COORD_W'(X), COORD_W'(Y)};
  localparam logic [LEN_W-1:0]  REM_ONE   = LEN_W'(1);

  state_e           state_q, state_d;
  flit_t            flit_q, flit_d;
  logic             enable_q, enable_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pkt_sent_q, pkt_sent_d;
  logic             err_self_q, err_self_d;

  logic    free;      // output register may take a new flit this cycle
  logic    self_hit;  // descriptor addressed to our own node
  logic    loading;   // SEND rules apply (SEND, or HEAD on the header-transfer cycle)
  logic    rem_zero;
  logic    last_word;
  logic    word_acc;
  header_t hdr;

  assign free      = !enable_q || ack_i;
  assign self_hit  = (msg_dst == SELF_ADDR);
  assign loading   = (state_q == S_SEND) || (state_q == S_HEAD && ack_i);
  assign rem_zero  = (rem_q == '0);
  assign last_word = (rem_q == REM_ONE);

  assign msg_ready  = (state_q == S_IDLE);
  assign data_ready = loading && !rem_zero && free;
  assign word_acc   = data_valid && data_ready;
  assign busy       = (state_q != S_IDLE);

  assign flit_o   = flit_q;
  assign enable_o = enable_q;
  assign pkt_sent = pkt_sent_q;
  assign err_self = err_self_q;

  assign hdr = '{rsvd: '0, dst_addr: addr_t'(msg_dst)};

  // State and datapath registers; synchronous reset abandons any packet in flight.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      flit_q     <= '0;
      enable_q   <= 1'b0;
      rem_q      <= '0;
      pkt_sent_q <= 1'b0;
      err_self_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flit_q     <= flit_d;
      enable_q   <= enable_d;
      rem_q      <= rem_d;
      pkt_sent_q <= pkt_sent_d;
      err_self_q <= err_self_d;
    end
  end

  // Next-state: advance on descriptor accept, header/tail transfer, or final word.
  // NOTE: default-assign every always_comb output first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (msg_valid && !self_hit) state_d = S_HEAD;
      S_HEAD: if (ack_i) state_d = (rem_zero || (word_acc && last_word)) ? S_LAST : S_SEND;
      S_SEND: if (word_acc && last_word) state_d = S_LAST;
      S_LAST: if (ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register loading: header on accept, body/tail per accepted word, bubbles when starved.
  always_comb begin
    flit_d     = flit_q;
    enable_d   = enable_q;
    rem_d      = rem_q;
    pkt_sent_d = 1'b0;
    err_self_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          if (self_hit) begin
            err_self_d = 1'b1;
          end else begin
            flit_d.flit_type = FT_HEADER;
            flit_d.payload   = hdr;
            enable_d         = 1'b1;
            rem_d            = msg_len;
          end
        end
      end
      S_HEAD, S_SEND: begin
        if (loading) begin
          if (state_q == S_HEAD && rem_zero) begin
            // Empty message: TAIL follows the header directly, no data consumed.
            flit_d.flit_type = FT_TAIL;
            flit_d.payload   = '0;
            enable_d         = 1'b1;
          end else if (word_acc) begin
            flit_d.flit_type = last_word ? FT_TAIL : FT_BODY;
            flit_d.payload   = data;
            enable_d         = 1'b1;
            rem_d            = rem_q - REM_ONE;
          end else if (free) begin
            enable_d = 1'b0;
          end
        end
      end
      S_LAST: begin
        if (ack_i) begin
          enable_d   = 1'b0;
          pkt_sent_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Handshake invariants: pending flit is frozen, idle emits nothing, data taken only in SEND window.
  a_hold_flit: assert property (@(posedge clk) disable iff (!rst)
    (enable_q && !ack_i) |=> (enable_q && $stable(flit_q)));
  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_IDLE) |-> !enable_q);
  a_data_window: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_IDLE || state_q == S_LAST || (state_q == S_HEAD && !ack_i)) |-> !data_ready);

endmodule

// File: tb/tb_noc_injector.sv
// tb_noc_injector: directed bench for noc_injector (X=1, Y=1, LEN_W=8).
// Flit layout: {type[1:0], payload[15:0]}; HEADER payload = {8'h00, x[3:0], y[3:0]}.
// Types: HEADER=1, BODY=2, TAIL=3.

module tb_noc_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  msg_dst;
  logic [7:0]  msg_len;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] data;
  logic [17:0] flit_o;
  logic        enable_o;
  logic        ack_i;
  logic        busy;
  logic        pkt_sent;
  logic        err_self;

  always #5 clk = ~clk;

  noc_injector #(.X(1), .Y(1), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_dst    (msg_dst),
    .msg_len    (msg_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .flit_o     (flit_o),
    .enable_o   (enable_o),
    .ack_i      (ack_i),
    .busy       (busy),
    .pkt_sent   (pkt_sent),
    .err_self   (err_self)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] words[$];
  int          idx = 0;
  logic [17:0] xfer_q[$];
  logic [17:0] exp_q[$];
  logic        pend_q = 1'b0;
  logic [17:0] pend_flit = '0;
  logic        consumed;
  logic        done;
  logic [7:0]  ack_pat = 8'b1010_1101;
  logic [6:0]  dv_pat  = 7'b101_1001;

  function automatic logic [17:0] hdr(input logic [7:0] a);
    return {2'b01, 8'h00, a};
  endfunction
  function automatic logic [17:0] body(input logic [15:0] d);
    return {2'b10, d};
  endfunction
  function automatic logic [17:0] tail(input logic [15:0] d);
    return {2'b11, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Log every transferred flit and verify pending flits are held.
  always @(posedge clk) begin
    if (pend_q) begin
      check("hold_enable", 32'(enable_o), 32'd1);
      check("hold_flit", 32'(flit_o), 32'(pend_flit));
    end
    pend_q    = rst && enable_o && !ack_i;
    pend_flit = flit_o;
    if (rst && enable_o && ack_i) xfer_q.push_back(flit_o);
  end

  task automatic drive(input logic ack, input logic gate);
    ack_i      = ack;
    data_valid = gate && (idx < words.size());
    data       = (idx < words.size()) ? words[idx] : 16'h0;
    #1;
  endtask

  task automatic clk_edge();
    consumed = rst && data_valid && data_ready;
    @(posedge clk);
    if (consumed) idx++;
    #1;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 32'(xfer_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < xfer_q.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), 32'(xfer_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_to_sent(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      drive(1'b1, 1'b1);
      clk_edge();
      msg_valid = 1'b0;
      seen = pkt_sent;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; msg_valid = 1'b0; msg_dst = '0; msg_len = '0;
    data_valid = 1'b0; data = '0; ack_i = 1'b0;
    clk_edge(); clk_edge();

    // Reset state
    check("rst_enable", 32'(enable_o), 0);
    check("rst_flit", 32'(flit_o), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pkt_sent", 32'(pkt_sent), 0);
    check("rst_err_self", 32'(err_self), 0);
    check("rst_msg_ready", 32'(msg_ready), 1);
    check("rst_data_ready", 32'(data_ready), 0);
    rst = 1'b1;
    drive(1'b0, 1'b0);
    clk_edge();

    // Test 1: len 3 to (2,3), ack held high, continuous data
    words = '{16'h000A, 16'h000B, 16'h000C}; idx = 0; xfer_q.delete();
    msg_valid = 1'b1; msg_dst = 8'h23; msg_len = 8'd3;
    drive(1'b1, 1'b1);
    check("t1_idle_data_ready", 32'(data_ready), 0);
    clk_edge();
    msg_valid = 1'b0;
    drive(1'b1, 1'b1);
    check("t1_hdr", 32'(flit_o), 32'(hdr(8'h23)));
    check("t1_hdr_en", 32'(enable_o), 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_head_msg_ready", 32'(msg_ready), 0);
    check("t1_hdr_xfer_data_ready", 32'(data_ready), 1);
    clk_edge();
    check("t1_body_a", 32'(flit_o), 32'(body(16'h000A)));
    drive(1'b1, 1'b1);
    clk_edge();
    check("t1_body_b", 32'(flit_o), 32'(body(16'h000B)));
    drive(1'b1, 1'b1);
    clk_edge();
    check("t1_tail_c", 32'(flit_o), 32'(tail(16'h000C)));
    check("t1_tail_en", 32'(enable_o), 1);
    drive(1'b1, 1'b1);
    check("t1_last_data_ready", 32'(data_ready), 0);
    clk_edge();
    check("t1_pkt_sent", 32'(pkt_sent), 1);
    check("t1_end_enable", 32'(enable_o), 0);
    check("t1_end_msg_ready", 32'(msg_ready), 1);
    drive(1'b1, 1'b0);
    clk_edge();
    check("t1_pkt_sent_pulse", 32'(pkt_sent), 0);
    exp_q = '{hdr(8'h23), body(16'h000A), body(16'h000B), tail(16'h000C)};
    check_log("t1_log");

    // Test 2: header back-pressured for 5 cycles
    words = '{16'h000A, 16'h000B, 16'h000C}; idx = 0; xfer_q.delete();
    msg_valid = 1'b1; msg_dst = 8'h23; msg_len = 8'd3;
    drive(1'b0, 1'b1);
    clk_edge();
    msg_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1);
      check($sformatf("t2_hdr_hold%0d", k), 32'(flit_o), 32'(hdr(8'h23)));
      check($sformatf("t2_data_ready%0d", k), 32'(data_ready), 0);
      clk_edge();
    end
    drive(1'b1, 1'b1);
    check("t2_hdr_6th", 32'(flit_o), 32'(hdr(8'h23)));
    check("t2_data_ready_on_ack", 32'(data_ready), 1);
    clk_edge();
    check("t2_body_a", 32'(flit_o), 32'(body(16'h000A)));
    drive(1'b1, 1'b1);
    clk_edge();
    check("t2_body_b", 32'(flit_o), 32'(body(16'h000B)));
    drive(1'b1, 1'b1);
    clk_edge();
    check("t2_tail_c", 32'(flit_o), 32'(tail(16'h000C)));
    drive(1'b1, 1'b1);
    clk_edge();
    check("t2_pkt_sent", 32'(pkt_sent), 1);
    exp_q = '{hdr(8'h23), body(16'h000A), body(16'h000B), tail(16'h000C)};
    check_log("t2_log");

    // Test 3: zero-length message to (0,1)
    words.delete(); idx = 0; xfer_q.delete();
    msg_valid = 1'b1; msg_dst = 8'h01; msg_len = 8'd0;
    drive(1'b1, 1'b1);
    clk_edge();
    msg_valid = 1'b0;
    drive(1'b1, 1'b1);
    check("t3_hdr", 32'(flit_o), 32'(hdr(8'h01)));
    check("t3_hdr_data_ready", 32'(data_ready), 0);
    clk_edge();
    drive(1'b1, 1'b1);
    check("t3_tail0", 32'(flit_o), 32'(tail(16'h0000)));
    check("t3_last_data_ready", 32'(data_ready), 0);
    clk_edge();
    check("t3_pkt_sent", 32'(pkt_sent), 1);
    exp_q = '{hdr(8'h01), tail(16'h0000)};
    check_log("t3_log");

    // Test 4: self-addressed message rejected, then a normal one
    words.delete(); idx = 0; xfer_q.delete();
    msg_valid = 1'b1; msg_dst = 8'h11; msg_len = 8'd2;
    drive(1'b1, 1'b0);
    clk_edge();
    msg_valid = 1'b0;
    check("t4_err_self", 32'(err_self), 1);
    check("t4_enable", 32'(enable_o), 0);
    check("t4_msg_ready", 32'(msg_ready), 1);
    check("t4_busy", 32'(busy), 0);
    drive(1'b1, 1'b0);
    clk_edge();
    check("t4_err_self_pulse", 32'(err_self), 0);
    words = '{16'h0055}; idx = 0;
    msg_valid = 1'b1; msg_dst = 8'h10; msg_len = 8'd1;
    run_to_sent("t4_next_sent", 12);
    exp_q = '{hdr(8'h10), tail(16'h0055)};
    check_log("t4_log");

    // Test 5: gappy data and irregular ack
    words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004}; idx = 0; xfer_q.delete();
    msg_valid = 1'b1; msg_dst = 8'h02; msg_len = 8'd4;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      drive(ack_pat[i % 8], (i < 7) ? dv_pat[i] : 1'b1);
      clk_edge();
      msg_valid = 1'b0;
      done = pkt_sent;
    end
    check("t5_sent", 32'(done), 1);
    exp_q = '{hdr(8'h02), body(16'h0001), body(16'h0002), body(16'h0003), tail(16'h0004)};
    check_log("t5_log");

    // Test 6: reset during the second BODY, then a clean packet
    words = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014}; idx = 0; xfer_q.delete();
    msg_valid = 1'b1; msg_dst = 8'h21; msg_len = 8'd5;
    drive(1'b1, 1'b1);
    clk_edge();
    msg_valid = 1'b0;
    drive(1'b1, 1'b1);
    clk_edge();
    drive(1'b1, 1'b1);
    clk_edge();
    check("t6_second_body", 32'(flit_o), 32'(body(16'h0011)));
    rst = 1'b0;
    drive(1'b1, 1'b1);
    clk_edge();
    rst = 1'b1;
    check("t6_rst_enable", 32'(enable_o), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_msg_ready", 32'(msg_ready), 1);
    check("t6_rst_flit", 32'(flit_o), 0);
    xfer_q.delete();
    words = '{16'h0077, 16'h0088}; idx = 0;
    msg_valid = 1'b1; msg_dst = 8'h32; msg_len = 8'd2;
    run_to_sent("t6_next_sent", 12);
    exp_q = '{hdr(8'h32), body(16'h0077), tail(16'h0088)};
    check_log("t6_log");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
